// File: rtl/ram_frame_streamer.sv
// ram_frame_streamer: reads a finished frame out of the frame RAM in raster order and streams it over valid/ready with a running checksum
module ram_frame_streamer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] RAM_A,
    output logic              RAM_OE,
    input  logic [DATA_W-1:0] RAM_Q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       checksum
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    state_t            state_q, state_d;
    logic              start_d_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d, inflight_last_q, inflight_last_d;
    logic [1:0]        count_q, count_d, keep, level;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              last0_q, last0_d, last1_q, last1_d;
    logic [15:0]       checksum_q, checksum_d;
    logic              trigger, pop;
    assign trigger    = start && !start_d_q;
    assign out_valid  = count_q != 2'd0;
    assign out_data   = data0_q;
    assign out_last   = out_valid && last0_q;
    assign pop        = out_valid && out_ready;
    assign busy       = state_q == RUN || state_q == DRAIN;
    assign frame_done = state_q == DONE;
    assign RAM_A      = state_q == RUN ? addr_q : '0;
    assign checksum   = checksum_q;
    assign keep       = count_q - {1'b0, pop};
    assign level      = keep + {1'b0, inflight_q};
    // Read issue, FIFO push/pop, checksum accumulation and frame sequencing
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        RAM_OE          = state_q == RUN && level <= 2'd1;
        inflight_d      = RAM_OE;
        inflight_last_d = RAM_OE && addr_q == ADDR_MAX;
        data0_d         = pop ? data1_q : data0_q;
        last0_d         = pop ? last1_q : last0_q;
        data1_d         = data1_q;
        last1_d         = last1_q;
        if (inflight_q && keep == 2'd0) begin
            data0_d = RAM_Q;
            last0_d = inflight_last_q;
        end
        if (inflight_q && keep == 2'd1) begin
            data1_d = RAM_Q;
            last1_d = inflight_last_q;
        end
        count_d    = level;
        checksum_d = pop ? checksum_q + 16'(out_data) : checksum_q;
        case (state_q)
            IDLE: if (trigger) begin
                state_d    = RUN;
                addr_d     = '0;
                checksum_d = '0;
                count_d    = '0;
                data0_d    = '0;
                data1_d    = '0;
                last0_d    = 1'b0;
                last1_d    = 1'b0;
            end
            RUN: if (RAM_OE) begin
                addr_d  = addr_q == ADDR_MAX ? addr_q : addr_q + ADDR_W'(1);
                state_d = addr_q == ADDR_MAX ? DRAIN : RUN;
            end
            DRAIN: state_d = pop && out_last ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            start_d_q       <= 1'b0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= '0;
            data0_q         <= '0;
            data1_q         <= '0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
            checksum_q      <= '0;
        end else begin
            state_q         <= state_d;
            start_d_q       <= start;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            data0_q         <= data0_d;
            data1_q         <= data1_d;
            last0_q         <= last0_d;
            last1_q         <= last1_d;
            checksum_q      <= checksum_d;
        end
    end
endmodule

// File: tb/tb_ram_frame_streamer.sv
// tb_ram_frame_streamer: scoreboard bench for the frame streamer on a reduced 1K-pixel frame
module tb_ram_frame_streamer;
    localparam int AW = 10;
    localparam int N  = 1 << AW;
    // Each upper-address value XORs a permutation of 0..255 (sum 32640), four of them: 130560 mod 2^16
    localparam logic [15:0] SUM_EXP  = 16'hFE00;
    localparam logic [7:0]  LAST_EXP = 8'hFC;
    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [AW-1:0] ram_a;
    logic          ram_oe, out_valid, out_last, busy, frame_done;
    logic [7:0]    ram_q = 8'h00, out_data;
    logic [15:0]   checksum;
    logic [8:0]    exp_q[$];
    logic [8:0]    e;
    logic          done_exp = 1'b0;
    int            total = 0, bad = 0, beats = 0, issued = 0, popped = 0;

    ram_frame_streamer #(.DATA_W(8), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .RAM_A(ram_a), .RAM_OE(ram_oe), .RAM_Q(ram_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .frame_done(frame_done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] px(input logic [AW-1:0] a);
        return a[7:0] ^ 8'(a >> 8);
    endfunction

    always @(posedge clk) if (ram_oe) ram_q <= px(ram_a);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            done_exp = 1'b0;
            issued   = 0;
            popped   = 0;
        end else begin
            chk("frame_done_timing", frame_done, done_exp);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_extra: got %0h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e[7:0]);
                    chk("beat_last", out_last, e[8]);
                end
                beats++;
                popped++;
            end
            if (ram_oe) issued++;
            chk("occupancy_le2", (issued - popped) <= 2, 1);
            done_exp = out_valid && out_ready && out_last;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load;
        for (int i = 0; i < N; i++) exp_q.push_back({i == N - 1, px(AW'(i))});
    endtask

    task automatic trig;
        start = 1'b0;
        tick;
        start = 1'b1;
        tick;
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_ram_a"}, ram_a, 0);
        chk({name, "_ram_oe"}, ram_oe, 0);
        chk({name, "_out_data"}, out_data, 0);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_out_last"}, out_last, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_frame_done"}, frame_done, 0);
        chk({name, "_checksum"}, checksum, 0);
    endtask

    task automatic wait_done(input string name, input bit toggle);
        int n = 0;
        while (!frame_done && n < 4 * N + 100) begin
            if (toggle) out_ready = !out_ready;
            tick;
            n++;
        end
        chk({name, "_done_seen"}, frame_done, 1);
        chk({name, "_checksum"}, checksum, SUM_EXP);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int b0, i0, n;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        tick;
        out_ready = 1'b1;
        load;
        trig;
        chk("lat_busy", busy, 1);
        chk("lat_oe0", ram_oe, 1);
        chk("lat_a0", ram_a, 0);
        chk("lat_valid0", out_valid, 0);
        tick;
        chk("lat_valid1", out_valid, 0);
        chk("lat_a1", ram_a, 1);
        tick;
        chk("lat_valid2", out_valid, 1);
        chk("lat_data2", out_data, 0);
        wait_done("full", 1'b0);
        chk("full_busy_low", busy, 0);
        tick;
        chk("full_done_pulse", frame_done, 0);

        out_ready = 1'b0;
        load;
        trig;
        wait_done("toggle", 1'b1);

        out_ready = 1'b0;
        load;
        i0 = issued;
        trig;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (k >= 2) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, 0);
            end
        end
        chk("stall_reads", issued - i0, 2);
        chk("stall_oe_low", ram_oe, 0);
        out_ready = 1'b1;
        b0 = beats;
        repeat (20) tick;
        chk("stall_resume_rate", beats - b0, 20);
        wait_done("stall", 1'b0);

        for (int k = 0; k < 5; k++) begin
            tick;
            chk("held_oe_low", ram_oe, 0);
            chk("held_busy_low", busy, 0);
        end
        load;
        trig;
        chk("retrig_checksum_clear", checksum, 0);
        chk("retrig_a0", ram_a, 0);
        chk("retrig_oe", ram_oe, 1);
        wait_done("retrig", 1'b0);

        load;
        trig;
        b0 = beats;
        n = 0;
        while (beats < b0 + 100 && n < 4 * N) begin
            tick;
            n++;
        end
        chk("midrst_reached", beats >= b0 + 100, 1);
        start = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset("midrst");
        tick;
        tick;
        chk("midrst_no_done", frame_done, 0);
        rst = 1'b0;
        tick;
        load;
        trig;
        wait_done("after_rst", 1'b0);

        load;
        trig;
        n = 0;
        while (!out_last && n < 4 * N) begin
            tick;
            n++;
        end
        chk("lastst_seen", out_last, 1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("lastst_last", out_last, 1);
            chk("lastst_data", out_data, LAST_EXP);
            chk("lastst_no_done", frame_done, 0);
        end
        out_ready = 1'b1;
        tick;
        chk("lastst_done", frame_done, 1);
        chk("lastst_checksum", checksum, SUM_EXP);
        chk("lastst_queue_empty", exp_q.size(), 0);
        tick;
        chk("lastst_done_single", frame_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
